// File: rtl/store_narrow_rmw_if.sv
// Store request / word-RAM bundle for store_narrow_rmw.
// STORE_BYTE_ENABLE_EN adds the mem_be lane strobe.
interface store_narrow_rmw_if #(
    parameter int AW = 30
);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_size;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
`ifdef STORE_BYTE_ENABLE_EN
    logic [3:0]    mem_be;
`endif

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid,
        output req_ready, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef STORE_BYTE_ENABLE_EN
        , output mem_be
`endif
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata, mem_rvalid,
        input  req_ready, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef STORE_BYTE_ENABLE_EN
        , input mem_be
`endif
    );
endinterface

// File: rtl/store_narrow_rmw.sv
// Narrows SB/SH/SW stores onto a word-only RAM via read-modify-write.
// Define STORE_BYTE_ENABLE_EN to write sub-words directly with mem_be lane strobes instead.
module store_narrow_rmw #(
    parameter int AW = 30
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    store_narrow_rmw_if.slave   bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [2:0]    r_state;
    logic          r_done, r_err, r_rd, r_wr;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          w_bad;

    assign w_bad = (bus.req_size == SZ_H && bus.req_addr[0])
                || (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00)
                || (bus.req_size == 2'b11);

`ifdef STORE_BYTE_ENABLE_EN
    logic [3:0]  r_be;
    logic [31:0] w_rep;
    logic [3:0]  w_be;

    // Data is replicated into every lane so the strobe alone picks the target bytes.
    always_comb begin
        w_rep = bus.req_data;
        w_be  = 4'b1111;
        if (bus.req_size == SZ_B) begin
            w_rep = {4{bus.req_data[7:0]}};
            w_be  = 4'b0001 << bus.req_addr[1:0];
        end else if (bus.req_size == SZ_H) begin
            w_rep = {2{bus.req_data[15:0]}};
            w_be  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign bus.mem_be = r_be;
`else
    logic [31:0]     r_data;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic [3:0]      w_sel;
    logic [3:0][7:0] w_merge;

    // Only byte and half reach the merge; lanes not selected keep the RAM contents.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_sel[k] = (r_size == SZ_B) ? (r_lane == 2'(k))
                                           : (r_lane[1] == ((k / 2) != 0));
        assign w_merge[k] = !w_sel[k] ? bus.mem_rdata[8*k +: 8]
                          : (r_size == SZ_B || (k % 2) == 0) ? r_data[7:0]
                          : r_data[15:8];
    end
`endif

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_rd    = r_rd;
    assign bus.mem_wr    = r_wr;
    assign bus.mem_wdata = r_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef STORE_BYTE_ENABLE_EN
            r_be    <= '0;
`else
            r_data  <= '0;
            r_size  <= '0;
            r_lane  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr <= bus.req_addr[AW+1:2];
`ifndef STORE_BYTE_ENABLE_EN
                        r_data <= bus.req_data;
                        r_size <= bus.req_size;
                        r_lane <= bus.req_addr[1:0];
`endif
                        if (w_bad) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
`ifdef STORE_BYTE_ENABLE_EN
                        end else begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_done  <= 1'b1;
                            r_wdata <= w_rep;
                            r_be    <= w_be;
                        end
`else
                        end else if (bus.req_size == SZ_W) begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_done  <= 1'b1;
                            r_wdata <= bus.req_data;
                        end else begin
                            r_state <= ST_READ;
                            r_rd    <= 1'b1;
                        end
`endif
                    end
                end
                ST_READ:  r_state <= ST_WAIT;
                ST_WAIT: begin
`ifndef STORE_BYTE_ENABLE_EN
                    if (bus.mem_rvalid) begin
                        r_state <= ST_WRITE;
                        r_wr    <= 1'b1;
                        r_done  <= 1'b1;
                        r_wdata <= w_merge;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_ERR:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_narrow_rmw.sv
// Table-driven bench for store_narrow_rmw plus a reset-in-WAIT sequence.
module tb_store_narrow_rmw;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    store_narrow_rmw_if #(.AW(30)) bus();
    store_narrow_rmw #(.AW(30)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave));

    typedef struct {
        string       name;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          late;
        logic        exp_err;
        logic [31:0] exp_wdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        int          exp_lat;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int   rd_c, n_rd, n_wr, end_c;
        logic g_err, g_wr;
        logic [31:0] g_wdata, g_maddr;
        logic [3:0]  g_be;
        rd_c = -100; n_rd = 0; n_wr = 0; end_c = 0;
        g_err = 0; g_wr = 0; g_wdata = 0; g_maddr = 0; g_be = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        bus.req_size  = v.size;
        bus.mem_rdata = v.rdata;
        @(posedge i_clk); #1;
        bus.req_valid = 1'b0;
        check({v.name, " busy"}, 32'(bus.req_ready), 32'd0);
        for (int c = 1; c <= 20 && end_c == 0; c++) begin
            if (c > 1) begin @(posedge i_clk); #1; end
            bus.mem_rvalid = 1'b0;
            if (bus.mem_rd) begin n_rd++; rd_c = c; end
            if (bus.mem_wr) n_wr++;
            if (bus.done || bus.err) begin
                end_c   = c;
                g_err   = bus.err;
                g_wr    = bus.mem_wr;
                g_wdata = bus.mem_wdata;
                g_maddr = 32'(bus.mem_addr);
`ifdef STORE_BYTE_ENABLE_EN
                g_be    = bus.mem_be;
`endif
            end
            if (end_c == 0 && c == rd_c + 1 + v.late) bus.mem_rvalid = 1'b1;
        end
        bus.mem_rvalid = 1'b0;
        check({v.name, " latency"}, 32'(end_c), 32'(v.exp_lat));
        check({v.name, " err"}, 32'(g_err), 32'(v.exp_err));
        check({v.name, " maddr"}, g_maddr, v.exp_maddr);
`ifdef STORE_BYTE_ENABLE_EN
        check({v.name, " rd count"}, 32'(n_rd), 32'd0);
`else
        check({v.name, " rd count"}, 32'(n_rd), (v.size != 2'b10 && !v.exp_err) ? 32'd1 : 32'd0);
`endif
        check({v.name, " wr count"}, 32'(n_wr), v.exp_err ? 32'd0 : 32'd1);
        if (!v.exp_err) begin
            check({v.name, " wr with done"}, 32'(g_wr), 32'd1);
            check({v.name, " wdata"}, g_wdata, v.exp_wdata);
`ifdef STORE_BYTE_ENABLE_EN
            check({v.name, " be"}, 32'(g_be), 32'(v.exp_be));
`endif
        end
        @(posedge i_clk); #1;
        check({v.name, " ready after"}, 32'(bus.req_ready), 32'd1);
    endtask

`ifdef STORE_BYTE_ENABLE_EN
    localparam int NV = 5;
`else
    localparam int NV = 11;
`endif
    vec_t vecs[NV];

    initial begin
        int n_wr, n_done;
`ifdef STORE_BYTE_ENABLE_EN
        vecs[0] = '{"sb01",  2'b00, 32'h01, 32'h7F, 32'h0, 0, 1'b0, 32'h7F7F7F7F, 32'h0, 4'b0010, 1};
        vecs[1] = '{"sh22",  2'b01, 32'h22, 32'hFFFF1234, 32'h0, 0, 1'b0, 32'h12341234, 32'h8, 4'b1100, 1};
        vecs[2] = '{"sh20",  2'b01, 32'h20, 32'hFFFF1234, 32'h0, 0, 1'b0, 32'h12341234, 32'h8, 4'b0011, 1};
        vecs[3] = '{"sw10",  2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 32'h4, 4'b1111, 1};
        vecs[4] = '{"sh21e", 2'b01, 32'h21, 32'h0, 32'h0, 0, 1'b1, 32'h0, 32'h8, 4'b0, 1};
`else
        vecs[0]  = '{"sw10",  2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 32'h4, 4'b0, 1};
        vecs[1]  = '{"sb13",  2'b00, 32'h13, 32'h000000A5, 32'h11223344, 1, 1'b0, 32'hA5223344, 32'h4, 4'b0, 4};
        vecs[2]  = '{"sh22",  2'b01, 32'h22, 32'hFFFF1234, 32'hCAFEBABE, 0, 1'b0, 32'h1234BABE, 32'h8, 4'b0, 3};
        vecs[3]  = '{"sh20",  2'b01, 32'h20, 32'hFFFF1234, 32'hCAFEBABE, 0, 1'b0, 32'hCAFE1234, 32'h8, 4'b0, 3};
        vecs[4]  = '{"sh21e", 2'b01, 32'h21, 32'h12345678, 32'h0, 0, 1'b1, 32'h0, 32'h8, 4'b0, 1};
        vecs[5]  = '{"sw02e", 2'b10, 32'h02, 32'h12345678, 32'h0, 0, 1'b1, 32'h0, 32'h0, 4'b0, 1};
        vecs[6]  = '{"sz3e",  2'b11, 32'h44, 32'h12345678, 32'h0, 0, 1'b1, 32'h0, 32'h11, 4'b0, 1};
        vecs[7]  = '{"sb00",  2'b00, 32'h00, 32'hFFFFFF5A, 32'h11223344, 3, 1'b0, 32'h1122335A, 32'h0, 4'b0, 6};
        vecs[8]  = '{"sb01",  2'b00, 32'h01, 32'hFFFFFF5A, 32'h11223344, 0, 1'b0, 32'h11225A44, 32'h0, 4'b0, 3};
        vecs[9]  = '{"sb02",  2'b00, 32'h02, 32'hFFFFFF5A, 32'h11223344, 0, 1'b0, 32'h115A3344, 32'h0, 4'b0, 3};
        vecs[10] = '{"swtop", 2'b10, 32'hFFFFFFFC, 32'h01234567, 32'h0, 0, 1'b0, 32'h01234567, 32'h3FFFFFFF, 4'b0, 1};
`endif
        bus.req_valid = 0; bus.req_addr = 0; bus.req_data = 0; bus.req_size = 0;
        bus.mem_rdata = 0; bus.mem_rvalid = 0;

        #12;
        check("rst ready", 32'(bus.req_ready), 32'd1);
        check("rst strobes", {28'd0, bus.done, bus.err, bus.mem_rd, bus.mem_wr}, 32'd0);
        check("rst wdata", bus.mem_wdata, 32'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

`ifndef STORE_BYTE_ENABLE_EN
        // SB abandoned by reset while in WAIT; a late rvalid must not trigger a write.
        bus.req_valid = 1'b1; bus.req_addr = 32'h13; bus.req_data = 32'hA5;
        bus.req_size = 2'b00; bus.mem_rdata = 32'h11223344;
        @(posedge i_clk); #1; bus.req_valid = 1'b0;
        @(posedge i_clk); #3;
        i_rst_n = 1'b0; #1;
        check("midrst ready", 32'(bus.req_ready), 32'd1);
        check("midrst strobes", {28'd0, bus.done, bus.err, bus.mem_rd, bus.mem_wr}, 32'd0);
        check("midrst maddr", 32'(bus.mem_addr), 32'd0);
        check("midrst wdata", bus.mem_wdata, 32'd0);
        @(negedge i_clk); i_rst_n = 1'b1;
        n_wr = 0; n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            bus.mem_rvalid = (c < 2);
            if (bus.mem_wr) n_wr++;
            if (bus.done) n_done++;
        end
        bus.mem_rvalid = 1'b0;
        check("stray rvalid wr", 32'(n_wr), 32'd0);
        check("stray rvalid done", 32'(n_done), 32'd0);
        check("stray rvalid ready", 32'(bus.req_ready), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
